// File: rtl/dac_spi_tx_pkg.sv
// dac_spi_tx_pkg: shared definitions for the DAC SPI transmitter.
//   - default word length and load-strobe length
//   - width of the sclk half-period divider
//   - FSM state encoding, also visible on the debug port of dac_spi_tx
`ifndef DAC_SPI_TX_PKG_SV
`define DAC_SPI_TX_PKG_SV

package dac_spi_tx_pkg;

  localparam int DEF_DAC_BITS    = 16;
  localparam int DEF_LDAC_CYCLES = 2;
  localparam int DIV_W           = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_CS_HOLD = 2'd2,
    ST_LDAC    = 2'd3
  } fsm_e;

endpackage

`endif

// File: rtl/dac_spi_tick.sv
// dac_spi_tick: reloadable down-counter that paces the sclk half-period.
//   clk, rst : clock, asynchronous active-high reset
//   load     : force the counter to period (word start)
//   en       : count while the transmitter is pacing sclk / cs hold
//   period   : reload value (half-period minus one)
//   tick     : high in the cycle the counter sits at zero while enabled;
//              the counter reloads to period on that same edge
`ifndef DAC_SPI_TICK_SV
`define DAC_SPI_TICK_SV

module dac_spi_tick
  import dac_spi_tx_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] delay_q, delay_d;

  assign tick = en && (delay_q == '0);

  always_comb begin
    delay_d = delay_q;
    if (load) begin
      delay_d = period;
    end else if (en) begin
      if (delay_q == '0) delay_d = period;
      else               delay_d = delay_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) delay_q <= '0;
    else     delay_q <= delay_d;
  end

endmodule

`endif

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: SPI mode-0 transmitter for a DAC with an active-low load strobe.
//   clkin       : single clock
//   rst         : asynchronous active-high reset
//   clk_divider : sclk half-period = clk_divider+1 clkin cycles, latched per word
//   go, data_i  : request to send data_i (sampled when go is accepted)
//   state       : 1 while a word is in flight (cs low through the ldac pulse)
//   pending     : a second word is waiting in the one-entry holding register
//   overrun     : one-cycle pulse when go arrives while pending is set
//   sclk, mosi, cs, ldac_n : DAC-side pins, all registered
//   fsm_dbg     : current FSM state for observation
//
// Handshake: go is a request sampled on every rising clkin edge. It is accepted
// straight into the shifter when idle, into the holding register when a word is
// in flight and the holder is empty, and otherwise dropped with an overrun pulse.
// There is no ready signal; pending tells the producer whether a go would be lost.
`ifndef DAC_SPI_TX_SV
`define DAC_SPI_TX_SV

module dac_spi_tx
  import dac_spi_tx_pkg::*;
#(
  parameter int DAC_BITS    = DEF_DAC_BITS,
  parameter int LDAC_CYCLES = DEF_LDAC_CYCLES
) (
  input  logic                clkin,
  input  logic                rst,
  input  logic [DIV_W-1:0]    clk_divider,
  input  logic                go,
  input  logic [DAC_BITS-1:0] data_i,
  output logic                state,
  output logic                pending,
  output logic                overrun,
  output logic                sclk,
  output logic                mosi,
  output logic                cs,
  output logic                ldac_n,
  output fsm_e                fsm_dbg
);

  localparam int CW = (DAC_BITS > 1) ? $clog2(DAC_BITS) : 1;
  localparam int LW = (LDAC_CYCLES > 1) ? $clog2(LDAC_CYCLES) : 1;

  fsm_e                fsm_q, fsm_d;
  logic                state_q, state_d;
  logic                pending_q, pending_d;
  logic                overrun_q, overrun_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                cs_q, cs_d;
  logic                ldac_n_q, ldac_n_d;
  logic [DAC_BITS-1:0] shift_q, shift_d;
  logic [DAC_BITS-1:0] hold_q, hold_d;
  logic [CW-1:0]       bitcnt_q, bitcnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [LW-1:0]       ldac_cnt_q, ldac_cnt_d;

  logic                start_word;
  logic [DAC_BITS-1:0] start_data;
  logic                tick_en;
  logic                tick;
  logic [DIV_W-1:0]    tick_period;

  // A word starts either from idle on go, or back-to-back from the holding
  // register on the edge that ends the ldac pulse.
  assign start_word = ((fsm_q == ST_IDLE) && go) ||
                      ((fsm_q == ST_LDAC) && (ldac_cnt_q == '0) && pending_q);
  assign start_data = (fsm_q == ST_IDLE) ? data_i : hold_q;

  // The counter only runs while pacing sclk or the cs hold; at word start it
  // is loaded with the freshly sampled divider, afterwards with the latched one.
  assign tick_en     = (fsm_q == ST_SHIFT) || (fsm_q == ST_CS_HOLD);
  assign tick_period = start_word ? clk_divider : div_q;

  dac_spi_tick u_tick (
    .clk    (clkin),
    .rst    (rst),
    .load   (start_word),
    .en     (tick_en),
    .period (tick_period),
    .tick   (tick)
  );

  always_comb begin
    fsm_d      = fsm_q;
    state_d    = state_q;
    pending_d  = pending_q;
    overrun_d  = 1'b0;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_d       = cs_q;
    ldac_n_d   = ldac_n_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    bitcnt_d   = bitcnt_q;
    div_d      = div_q;
    ldac_cnt_d = ldac_cnt_q;

    // Queueing while busy; state_q is still 1 on the ldac exit edge, so a
    // go landing there is queued rather than started.
    if (go && state_q) begin
      if (pending_q) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = 1'b1;
        hold_d    = data_i;
      end
    end

    case (fsm_q)
      ST_IDLE: ;
      ST_SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bitcnt_q == '0) begin
              fsm_d  = ST_CS_HOLD;
              mosi_d = 1'b0;
            end else begin
              shift_d  = {shift_q[DAC_BITS-2:0], 1'b0};
              mosi_d   = shift_q[DAC_BITS-2];
              bitcnt_d = bitcnt_q - 1'b1;
            end
          end
        end
      end
      ST_CS_HOLD: begin
        if (tick) begin
          cs_d       = 1'b1;
          ldac_n_d   = 1'b0;
          ldac_cnt_d = LW'(LDAC_CYCLES - 1);
          fsm_d      = ST_LDAC;
        end
      end
      ST_LDAC: begin
        if (ldac_cnt_q != '0) begin
          ldac_cnt_d = ldac_cnt_q - 1'b1;
        end else begin
          ldac_n_d = 1'b1;
          if (!pending_q) begin
            fsm_d   = ST_IDLE;
            state_d = 1'b0;
          end
        end
      end
      default: fsm_d = ST_IDLE;
    endcase

    if (start_word) begin
      fsm_d    = ST_SHIFT;
      state_d  = 1'b1;
      cs_d     = 1'b0;
      shift_d  = start_data;
      mosi_d   = start_data[DAC_BITS-1];
      bitcnt_d = CW'(DAC_BITS - 1);
      div_d    = clk_divider;
      if (fsm_q == ST_LDAC) pending_d = 1'b0;
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      fsm_q      <= ST_IDLE;
      state_q    <= 1'b0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_q       <= 1'b1;
      ldac_n_q   <= 1'b1;
      shift_q    <= '0;
      hold_q     <= '0;
      bitcnt_q   <= '0;
      div_q      <= '0;
      ldac_cnt_q <= '0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_q       <= cs_d;
      ldac_n_q   <= ldac_n_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      bitcnt_q   <= bitcnt_d;
      div_q      <= div_d;
      ldac_cnt_q <= ldac_cnt_d;
    end
  end

  assign state   = state_q;
  assign pending = pending_q;
  assign overrun = overrun_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs      = cs_q;
  assign ldac_n  = ldac_n_q;
  assign fsm_dbg = fsm_q;

endmodule

`endif

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: directed bench for dac_spi_tx (DAC_BITS=16, LDAC_CYCLES=2).
// A negedge monitor reconstructs each word and its timing from the pins;
// the main sequence drives at posedge+1 and checks against hand-computed values.
module tb_dac_spi_tx;
  import dac_spi_tx_pkg::*;

  logic        clkin = 1'b0;
  logic        rst   = 1'b1;
  logic [2:0]  clk_divider = 3'd0;
  logic        go = 1'b0;
  logic [15:0] data_i = 16'h0;
  logic        state, pending, overrun, sclk, mosi, cs, ldac_n;
  fsm_e        fsm_dbg;

  int vectors = 0;
  int miscompares = 0;

  dac_spi_tx dut (
    .clkin       (clkin),
    .rst         (rst),
    .clk_divider (clk_divider),
    .go          (go),
    .data_i      (data_i),
    .state       (state),
    .pending     (pending),
    .overrun     (overrun),
    .sclk        (sclk),
    .mosi        (mosi),
    .cs          (cs),
    .ldac_n      (ldac_n),
    .fsm_dbg     (fsm_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clkin = ~clkin;

  int cyc = 0;
  always @(posedge clkin) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- pin monitor ----------------
  logic [15:0] got_q[$];
  int bits_q[$], frise_q[$], per_q[$], slen_q[$], lw_q[$];
  logic [15:0] rx_word = 16'h0;
  int rx_bits = 0, rise1 = 0, rise2 = 0, fall_cyc = 0;
  int cs_fall_cyc = 0, cs_rise_cyc = 0, ldac_fall_cyc = 0;
  int last_gap = 0, ldac_lead = 0, ldac_pulses = 0, cs_falls = 0;
  logic p_cs = 1'b1, p_sclk = 1'b0, p_ldac = 1'b1;

  always @(negedge clkin) begin
    if (p_cs && !cs) begin
      cs_falls++;
      cs_fall_cyc = cyc;
      last_gap    = cyc - cs_rise_cyc;
      rx_bits     = 0;
      rx_word     = 16'h0;
    end
    if (!p_sclk && sclk) begin
      rx_word = {rx_word[14:0], mosi};
      if (rx_bits == 0) rise1 = cyc;
      if (rx_bits == 1) rise2 = cyc;
      rx_bits++;
    end
    if (p_sclk && !sclk) fall_cyc = cyc;
    if (!p_cs && cs) begin
      cs_rise_cyc = cyc;
      got_q.push_back(rx_word);
      bits_q.push_back(rx_bits);
      frise_q.push_back(rise1 - cs_fall_cyc);
      per_q.push_back(rise2 - rise1);
      slen_q.push_back(fall_cyc - cs_fall_cyc);
    end
    if (p_ldac && !ldac_n) begin
      ldac_fall_cyc = cyc;
      ldac_lead     = cyc - cs_rise_cyc;
      ldac_pulses++;
    end
    if (!p_ldac && ldac_n) lw_q.push_back(cyc - ldac_fall_cyc);
    p_cs   = cs;
    p_sclk = sclk;
    p_ldac = ldac_n;
  end

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] d);
    go     = 1'b1;
    data_i = d;
    tick();
    go     = 1'b0;
  endtask

  task automatic clear_mon();
    got_q.delete(); bits_q.delete(); frise_q.delete();
    per_q.delete(); slen_q.delete(); lw_q.delete();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (state !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(n < budget), 32'd1);
    tick();
    tick();
  endtask

  // ---------------- directed sequence ----------------
  int falls_before, pulses_before, n;

  initial begin
    // Reset, with go held high: nothing may start.
    go = 1'b1;
    data_i = 16'hDEAD;
    repeat (4) tick();
    chk("rst_cs", cs, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_ldac_n", ldac_n, 1);
    chk("rst_state", state, 0);
    chk("rst_pending", pending, 0);
    chk("rst_overrun", overrun, 0);
    go = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_no_word", 32'(cs_falls), 32'd0);

    // A5C3 at divider 0
    clear_mon();
    clk_divider = 3'd0;
    send(16'hA5C3);
    chk("a_state", state, 1);
    chk("a_cs_low", cs, 0);
    wait_idle(200);
    chk("a_nwords", 32'(got_q.size()), 32'd1);
    chk("a_word", got_q[0], 16'hA5C3);
    chk("a_bits", 32'(bits_q[0]), 32'd16);
    chk("a_first_rise", 32'(frise_q[0]), 32'd1);
    chk("a_period", 32'(per_q[0]), 32'd2);
    chk("a_ldac_lead", 32'(ldac_lead), 32'd0);
    chk("a_ldac_width", 32'(lw_q[0]), 32'd2);
    chk("a_idle_cs", cs, 1);
    chk("a_idle_ldac", ldac_n, 1);

    // 8001 at divider 3
    clear_mon();
    clk_divider = 3'd3;
    send(16'h8001);
    wait_idle(400);
    chk("b_word", got_q[0], 16'h8001);
    chk("b_first_rise", 32'(frise_q[0]), 32'd4);
    chk("b_period", 32'(per_q[0]), 32'd8);
    chk("b_shift_len", 32'(slen_q[0]), 32'd128);
    chk("b_idle_mosi", mosi, 0);

    // Back-to-back with a queued word and a dropped third word
    clear_mon();
    clk_divider = 3'd0;
    send(16'h1234);
    repeat (5) tick();
    send(16'hFFFF);
    chk("c_pending", pending, 1);
    repeat (5) tick();
    send(16'h0F0F);
    chk("c_overrun", overrun, 1);
    tick();
    chk("c_overrun_clr", overrun, 0);
    chk("c_pending_kept", pending, 1);
    wait_idle(400);
    chk("c_nwords", 32'(got_q.size()), 32'd2);
    chk("c_word0", got_q[0], 16'h1234);
    chk("c_word1", got_q[1], 16'hFFFF);
    chk("c_cs_gap", 32'(last_gap), 32'd2);
    chk("c_pending_end", pending, 0);

    // Reset in the middle of a word with a word queued
    clear_mon();
    clk_divider = 3'd1;
    send(16'h5A5A);
    tick();
    send(16'h1111);
    chk("d_pending", pending, 1);
    n = 0;
    while (rx_bits < 7 && n < 200) begin
      tick();
      n++;
    end
    chk("d_reach_bit7", 32'(n < 200), 32'd1);
    falls_before  = cs_falls;
    pulses_before = ldac_pulses;
    #2 rst = 1'b1;
    #1;
    chk("d_cs", cs, 1);
    chk("d_sclk", sclk, 0);
    chk("d_ldac_n", ldac_n, 1);
    chk("d_pending_clr", pending, 0);
    chk("d_state", state, 0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (80) tick();
    chk("d_no_ldac", 32'(ldac_pulses), 32'(pulses_before));
    chk("d_no_restart", 32'(cs_falls), 32'(falls_before));

    // Divider change mid-word applies to the next word only
    clear_mon();
    clk_divider = 3'd1;
    send(16'h3C3C);
    repeat (3) tick();
    clk_divider = 3'd5;
    send(16'hC3C3);
    wait_idle(600);
    chk("e_nwords", 32'(got_q.size()), 32'd2);
    chk("e_word0", got_q[0], 16'h3C3C);
    chk("e_period0", 32'(per_q[0]), 32'd4);
    chk("e_word1", got_q[1], 16'hC3C3);
    chk("e_period1", 32'(per_q[1]), 32'd12);
    chk("e_first_rise1", 32'(frise_q[1]), 32'd6);
    chk("e_shift_len1", 32'(slen_q[1]), 32'd192);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
